issue_entry_queue: RTL and testbench

Parameterised FIFO of decoded scoreboard entries between the decode stage and the load/store reordering stage in the CVA6 issue path. It absorbs decode bursts while the reorderer or issue stage stalls, so decode keeps running. It also reports how many buffered entries are memory operations, which lets the reorderer see LSU pressure ahead of time. The block is single-clock and is cleared completely by flush.

---
 rtl/issue_entry_queue.sv | 209 ++++++++++++++++++++
 tb/tb_issue_entry_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_entry_queue.sv
// ---------------------------------------------------------------------------
// issue_entry_queue
//
// FIFO of decoded scoreboard entries between decode and the load/store
// reordering stage. It absorbs decode bursts while the downstream stages
// stall, and it counts how many buffered entries are memory operations so
// that the reorderer can see LSU pressure ahead of time.
//
// Optional feature: define ISSUE_QUEUE_BYPASS_EN to present an incoming
// entry combinationally on the head outputs while the queue is empty.
//
// Ports:
//   clk_i                  clock, rising edge
//   rst_ni                 asynchronous active-low reset
//   flush_i                synchronous flush; clears pointers and counters
//   decoded_instr_i        entry from decode
//   decoded_instr_valid_i  decode entry valid
//   is_ctrl_flow_i         decode entry is control flow
//   decoded_instr_ack_o    entry accepted this cycle (!full && !flush)
//   issue_entry_o          head entry to the reorderer ('0 when empty)
//   issue_entry_valid_o    head valid
//   is_ctrl_flow_o         head control-flow flag
//   issue_instr_ack_i      downstream consumed the head
//   usage_o                number of stored entries
//   mem_op_count_o         stored entries whose fu is LOAD or STORE
//   full_o                 usage_o == DEPTH
//
// A minimal ariane_pkg is provided here so the block is self-contained.
// ---------------------------------------------------------------------------

package ariane_pkg;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6,
        FPU       = 4'd7
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        valid;
    } scoreboard_entry_t;

endpackage

module issue_entry_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  ariane_pkg::scoreboard_entry_t       decoded_instr_i,
    input  logic                                decoded_instr_valid_i,
    input  logic                                is_ctrl_flow_i,
    output logic                                decoded_instr_ack_o,
    output ariane_pkg::scoreboard_entry_t       issue_entry_o,
    output logic                                issue_entry_valid_o,
    output logic                                is_ctrl_flow_o,
    input  logic                                issue_instr_ack_i,
    output logic [$clog2(DEPTH):0]              usage_o,
    output logic [$clog2(DEPTH):0]              mem_op_count_o,
    output logic                                full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Memory operations are the entries that end up in the LSU.
    function automatic logic is_mem_op(input ariane_pkg::fu_t fu);
        logic res;
        case (fu)
            ariane_pkg::LOAD,
            ariane_pkg::STORE: res = 1'b1;
            default:           res = 1'b0;
        endcase
        return res;
    endfunction

    // Storage is never cleared: an empty queue forces the outputs to zero,
    // so stale slot contents are unobservable.
    ariane_pkg::scoreboard_entry_t sbe_mem_r [DEPTH];
    logic                          cf_mem_r  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] usage_r;
    logic [CNT_W-1:0] mem_cnt_r;

    logic                          empty_s;
    logic                          full_s;
    logic                          ack_s;
    logic                          push_s;
    logic                          pop_s;
    logic                          push_mem_s;
    logic                          pop_mem_s;
    logic                          bypass_s;
    logic                          bypass_take_s;
    ariane_pkg::scoreboard_entry_t head_sbe_s;
    logic                          head_cf_s;

    // Handshake decode: push/pop qualification and bypass detection.
    always_comb begin
        empty_s    = (usage_r == CNT_ZERO);
        full_s     = (usage_r == DEPTH_C);
        // Upstream ack never looks at downstream ack: no comb path across.
        ack_s      = !full_s && !flush_i;
        head_sbe_s = sbe_mem_r[rd_ptr_r];
        head_cf_s  = cf_mem_r[rd_ptr_r];
`ifdef ISSUE_QUEUE_BYPASS_EN
        bypass_s      = empty_s && decoded_instr_valid_i;
        // An entry consumed straight through the bypass is never written.
        bypass_take_s = bypass_s && issue_instr_ack_i && !flush_i;
`else
        bypass_s      = 1'b0;
        bypass_take_s = 1'b0;
`endif
        push_s     = decoded_instr_valid_i && ack_s && !bypass_take_s;
        pop_s      = !empty_s && issue_instr_ack_i && !flush_i;
        push_mem_s = push_s && is_mem_op(decoded_instr_i.fu);
        pop_mem_s  = pop_s && is_mem_op(head_sbe_s.fu);
    end

    // Output mux: head slot, bypassed input, or zero when nothing to show.
    always_comb begin
        issue_entry_o       = '0;
        issue_entry_valid_o = 1'b0;
        is_ctrl_flow_o      = 1'b0;
        if (!empty_s) begin
            issue_entry_o       = head_sbe_s;
            issue_entry_valid_o = 1'b1;
            is_ctrl_flow_o      = head_cf_s;
        end else if (bypass_s && !flush_i) begin
            issue_entry_o       = decoded_instr_i;
            issue_entry_valid_o = 1'b1;
            is_ctrl_flow_o      = is_ctrl_flow_i;
        end else begin
            issue_entry_o       = '0;
            issue_entry_valid_o = 1'b0;
            is_ctrl_flow_o      = 1'b0;
        end
        decoded_instr_ack_o = ack_s;
        usage_o             = usage_r;
        mem_op_count_o      = mem_cnt_r;
        full_o              = full_s;
    end

    // Slot write on every accepted push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            sbe_mem_r[wr_ptr_r] <= decoded_instr_i;
            cf_mem_r[wr_ptr_r]  <= is_ctrl_flow_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush wipes everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            usage_r   <= CNT_ZERO;
            mem_cnt_r <= CNT_ZERO;
        end else if (flush_i) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            usage_r   <= CNT_ZERO;
            mem_cnt_r <= CNT_ZERO;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   usage_r <= usage_r + CNT_ONE;
                2'b01:   usage_r <= usage_r - CNT_ONE;
                default: usage_r <= usage_r;
            endcase
            case ({push_mem_s, pop_mem_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + CNT_ONE;
                2'b01:   mem_cnt_r <= mem_cnt_r - CNT_ONE;
                default: mem_cnt_r <= mem_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_entry_queue.sv
// Directed bench for issue_entry_queue with a queue-based reference model.
module tb_issue_entry_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        scoreboard_entry_t sbe;
        logic              cf;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    scoreboard_entry_t din;
    logic              vld;
    logic              cf_in;
    logic              iack;
    logic              ack_o;
    scoreboard_entry_t entry_o;
    logic              valid_o;
    logic              cf_o;
    logic [CNT_W-1:0]  usage_o;
    logic [CNT_W-1:0]  mem_o;
    logic              full_o;

    ent_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   chk_en = 1'b0;

    issue_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .decoded_instr_i       (din),
        .decoded_instr_valid_i (vld),
        .is_ctrl_flow_i        (cf_in),
        .decoded_instr_ack_o   (ack_o),
        .issue_entry_o         (entry_o),
        .issue_entry_valid_o   (valid_o),
        .is_ctrl_flow_o        (cf_o),
        .issue_instr_ack_i     (iack),
        .usage_o               (usage_o),
        .mem_op_count_o        (mem_o),
        .full_o                (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_mem();
        int n = 0;
        foreach (q[i]) if (q[i].sbe.fu == LOAD || q[i].sbe.fu == STORE) n++;
        return n;
    endfunction

    function automatic bit model_bypass();
`ifdef ISSUE_QUEUE_BYPASS_EN
        return (q.size() == 0) && (vld === 1'b1) && (flush === 1'b0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_valid();
        return (q.size() > 0) || model_bypass();
    endfunction

    function automatic scoreboard_entry_t model_entry();
        if (q.size() > 0) return q[0].sbe;
        if (model_bypass()) return din;
        return '0;
    endfunction

    function automatic logic model_cf();
        if (q.size() > 0) return q[0].cf;
        if (model_bypass()) return cf_in;
        return 1'b0;
    endfunction

    // Apply one clock edge worth of queue behaviour using the current inputs.
    task automatic model_step();
        bit popped;
        bit pushed;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            popped = model_valid() && iack;
            pushed = vld && (q.size() != DEPTH);
            if (!(model_bypass() && popped)) begin
                if (popped) void'(q.pop_front());
                if (pushed) q.push_back('{sbe: din, cf: cf_in});
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 128'(valid_o), 128'(model_valid()));
            chk("entry", 128'(entry_o), 128'(model_entry()));
            chk("ctrl_flow", 128'(cf_o), 128'(model_cf()));
            chk("usage", 128'(usage_o), 128'(q.size()));
            chk("mem_op_count", 128'(mem_o), 128'(model_mem()));
            chk("full", 128'(full_o), 128'(q.size() == DEPTH));
            chk("ack", 128'(ack_o), 128'((q.size() != DEPTH) && !flush));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic v, input fu_t fu, input logic [31:0] pc,
                          input logic cf, input logic ak, input logic fl);
        scoreboard_entry_t e;
        e       = '0;
        e.pc    = pc;
        e.fu    = fu;
        e.op    = pc[7:0];
        e.rd    = pc[4:0];
        e.valid = 1'b1;
        din   = e;
        vld   = v;
        cf_in = cf;
        iack  = ak;
        flush = fl;
    endtask

    initial begin
        fu_t fill_fu[4];
        int  mem_seq[4];
        fill_fu = '{LOAD, ALU, STORE, ALU};
        mem_seq = '{2, 1, 1, 0};

        rst_n = 1'b0;
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("reset_valid", 128'(valid_o), 128'(0));
        chk("reset_usage", 128'(usage_o), 128'(0));
        chk("reset_ack", 128'(ack_o), 128'(1));
        chk("reset_entry", 128'(entry_o), 128'(0));
        tick();

        // Fill to DEPTH with no downstream ack.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, fill_fu[i], 32'(i + 1), (i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, ALU, 32'd5, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fill_usage", 128'(usage_o), 128'(4));
        chk("fill_full", 128'(full_o), 128'(1));
        chk("fill_ack", 128'(ack_o), 128'(0));
        chk("fill_mem", 128'(mem_o), 128'(2));
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, NONE, 32'd0, 1'b0, 1'b1, 1'b0);
            #1;
            chk("drain_fu", 128'(entry_o.fu), 128'(fill_fu[i]));
            chk("drain_pc", 128'(entry_o.pc), 128'(i + 1));
            chk("drain_mem", 128'(mem_o), 128'(mem_seq[i]));
            tick();
        end
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("drain_mem_end", 128'(mem_o), 128'(0));
        chk("drain_usage_end", 128'(usage_o), 128'(0));
        tick();

        // Streaming at usage 1: pointers wrap several times.
        set_in(1'b1, LOAD, 32'd100, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, (i % 3 == 0) ? STORE : ALU, 32'(101 + i), 1'(i), 1'b1, 1'b0);
            #1;
            chk("stream_usage", 128'(usage_o), 128'(1));
            chk("stream_pc", 128'(entry_o.pc), 128'(100 + i));
            tick();
        end
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stream_empty", 128'(usage_o), 128'(0));
        tick();

        // Flush at usage 3 with concurrent push and pop.
        set_in(1'b1, LOAD, 32'd200, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, STORE, 32'd201, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, ALU, 32'd202, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, STORE, 32'd203, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_ack", 128'(ack_o), 128'(0));
        chk("flush_usage_pre", 128'(usage_o), 128'(3));
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flush_usage", 128'(usage_o), 128'(0));
        chk("flush_mem", 128'(mem_o), 128'(0));
        chk("flush_valid", 128'(valid_o), 128'(0));
        tick();

        // Full with a same-cycle pop: push deferred one cycle.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, (i == 1) ? LOAD : ALU, 32'(300 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, STORE, 32'd304, 1'b1, 1'b1, 1'b0);
        #1;
        chk("fullpop_ack", 128'(ack_o), 128'(0));
        chk("fullpop_usage", 128'(usage_o), 128'(4));
        tick();
        set_in(1'b1, STORE, 32'd304, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fullpop_ack_next", 128'(ack_o), 128'(1));
        chk("fullpop_usage_next", 128'(usage_o), 128'(3));
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fullpop_refill", 128'(usage_o), 128'(4));
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, NONE, 32'd0, 1'b0, 1'b1, 1'b0);
            #1;
            chk("fullpop_order", 128'(entry_o.pc), 128'(301 + i));
            tick();
        end
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Empty queue, STORE with same-cycle downstream ack.
        set_in(1'b1, STORE, 32'd400, 1'b1, 1'b1, 1'b0);
        #1;
`ifdef ISSUE_QUEUE_BYPASS_EN
        chk("byp_valid", 128'(valid_o), 128'(1));
        chk("byp_entry", 128'(entry_o), 128'(din));
        chk("byp_cf", 128'(cf_o), 128'(1));
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp_usage", 128'(usage_o), 128'(0));
        chk("byp_mem", 128'(mem_o), 128'(0));
        chk("byp_valid_next", 128'(valid_o), 128'(0));
`else
        chk("nobyp_valid", 128'(valid_o), 128'(0));
        chk("nobyp_entry", 128'(entry_o), 128'(0));
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("nobyp_head_valid", 128'(valid_o), 128'(1));
        chk("nobyp_head_fu", 128'(entry_o.fu), 128'(STORE));
        chk("nobyp_head_pc", 128'(entry_o.pc), 128'(400));
        chk("nobyp_usage", 128'(usage_o), 128'(1));
        chk("nobyp_mem", 128'(mem_o), 128'(1));
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
`endif
        tick();

        // Flush while an entry arrives at an empty queue: nothing is shown.
        set_in(1'b1, LOAD, 32'd401, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flush_empty_valid", 128'(valid_o), 128'(0));
        tick();
        // Arrival at empty queue without downstream ack is stored.
        set_in(1'b1, LOAD, 32'd402, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("noack_usage", 128'(usage_o), 128'(1));
        chk("noack_mem", 128'(mem_o), 128'(1));
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // Asynchronous reset mid-operation.
        set_in(1'b1, STORE, 32'd500, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, LOAD, 32'd501, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b0, NONE, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_usage", 128'(usage_o), 128'(0));
        chk("arst_valid", 128'(valid_o), 128'(0));
        chk("arst_mem", 128'(mem_o), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("arst_release_valid", 128'(valid_o), 128'(0));
        chk("arst_release_ack", 128'(ack_o), 128'(1));
        tick();
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
